// File: rtl/omsp_hash_frontend.sv
// Packs 16-bit register writes big-endian into CORE_W beats for a hash core and streams the digest back 16 bits per read.
// A beat reaches an empty FIFO head one cycle after completion; a full FIFO or a pending terminator drops writes and sets sticky overflow.
module omsp_hash_frontend #(
   parameter int CORE_W     = 32,
   parameter int DIGEST_W   = 512,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [1:0]                cmd_in,
   input  logic [15:0]               data,
   input  logic                      data_size,
   output logic [15:0]               hash,
   output logic                      busy,
   output logic                      ready_for_data,
   output logic                      overflow,
   output logic [CORE_W-1:0]         core_data,
   output logic [$clog2(CORE_W/8):0] core_bytes,
   output logic                      core_last,
   output logic                      core_valid,
   input  logic                      core_ready,
   input  logic                      core_busy,
   input  logic [DIGEST_W-1:0]       core_digest,
   input  logic                      core_digest_valid
);
   localparam int BYTES  = CORE_W / 8;
   localparam int CNT_W  = $clog2(BYTES);
   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W:0]    FULL_BYTES = (CNT_W + 1)'(BYTES);
   localparam logic [PTR_W-1:0]  LAST_PTR   = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [FCNT_W-1:0] FIFO_FULL  = FCNT_W'(FIFO_DEPTH);

   typedef struct packed {
      logic [CORE_W-1:0] dat;
      logic [CNT_W:0]    bytes;
      logic              last;
   } beat_t;

   typedef enum logic [2:0] {IDLE, MSG, FLUSH, WAIT_DIGEST, DIGEST} state_t;

   state_t              state_q, state_d;
   logic [CORE_W-1:0]   pack_q, pack_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   beat_t               mem_q [FIFO_DEPTH];
   beat_t               mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
   logic [DIGEST_W-1:0] dig_q, dig_d;
   logic [15:0]         hash_q, hash_d;
   logic                ovf_q, ovf_d, rdy_q, rdy_d, busy_q, busy_d;

   logic                wr, rd, acc, push, pop;
   logic [15:0]         ins;
   logic [CORE_W-1:0]   merged;
   logic [CNT_W:0]      cnt_sum;
   beat_t               push_beat, head;

   always_comb begin
      wr  = (cmd_in == 2'b10);
      rd  = (cmd_in == 2'b01);
      acc = wr && rdy_q;
      pop = core_valid && core_ready;
      // Bytes beyond the last slot shift out; that is exactly the low half of a split word.
      ins     = data_size ? data : {data[7:0], 8'h00};
      merged  = pack_q | ({ins, {(CORE_W - 16){1'b0}}} >> {cnt_q, 3'b000});
      cnt_sum = {1'b0, cnt_q} + {{(CNT_W - 1){1'b0}}, data_size, !data_size};

      state_d   = state_q;
      pack_d    = pack_q;
      cnt_d     = cnt_q;
      push      = 1'b0;
      push_beat = '0;
      ovf_d     = ovf_q | (wr && !rdy_q);
      dig_d     = dig_q;
      hash_d    = hash_q;

      if (acc) begin
         if (cnt_sum >= FULL_BYTES) begin
            push      = 1'b1;
            push_beat = {merged, FULL_BYTES, 1'b0};
            pack_d    = (cnt_sum > FULL_BYTES) ? {data[7:0], {(CORE_W - 8){1'b0}}} : '0;
            cnt_d     = (cnt_sum > FULL_BYTES) ? CNT_W'(1) : '0;
         end else begin
            pack_d = merged;
            cnt_d  = cnt_sum[CNT_W-1:0];
         end
      end

      case (state_q)
         IDLE, DIGEST: if (acc) state_d = MSG;
         MSG:          if (!wr) state_d = FLUSH;
         FLUSH: begin
            if (fcnt_q != FIFO_FULL) begin
               push      = 1'b1;
               push_beat = {pack_q, {1'b0, cnt_q}, 1'b1};
               pack_d    = '0;
               cnt_d     = '0;
               state_d   = WAIT_DIGEST;
            end
         end
         WAIT_DIGEST: begin
            if (core_digest_valid) begin
               dig_d   = core_digest;
               state_d = DIGEST;
            end
         end
         default: state_d = IDLE;
      endcase

      // Rotating the register keeps the next chunk on top and wraps after the last one.
      if (state_q == DIGEST && rd) begin
         hash_d = dig_q[DIGEST_W-1 -: 16];
         dig_d  = (dig_q << 16) | (dig_q >> (DIGEST_W - 16));
      end

      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_beat;
         wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
      fcnt_d = fcnt_q + FCNT_W'(push) - FCNT_W'(pop);

      // The terminator stays pending until its digest returns, so writes are refused meanwhile.
      rdy_d  = (fcnt_d != FIFO_FULL) && (state_d != FLUSH) && (state_d != WAIT_DIGEST);
      busy_d = (state_d == MSG) || (state_d == FLUSH) || (state_d == WAIT_DIGEST) || (fcnt_d != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         pack_q   <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fcnt_q   <= '0;
         dig_q    <= '0;
         hash_q   <= '0;
         ovf_q    <= 1'b0;
         rdy_q    <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         pack_q   <= pack_d;
         cnt_q    <= cnt_d;
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fcnt_q   <= fcnt_d;
         dig_q    <= dig_d;
         hash_q   <= hash_d;
         ovf_q    <= ovf_d;
         rdy_q    <= rdy_d;
         busy_q   <= busy_d;
      end
   end

   always_comb begin
      head           = mem_q[rd_ptr_q];
      core_valid     = (fcnt_q != '0);
      core_data      = core_valid ? head.dat : '0;
      core_bytes     = core_valid ? head.bytes : '0;
      core_last      = core_valid && head.last;
      hash           = hash_q;
      overflow       = ovf_q;
      ready_for_data = rdy_q;
      busy           = busy_q || core_busy;
   end
endmodule

// File: tb/tb_omsp_hash_frontend.sv
`timescale 1ns/1ps
module tb_omsp_hash_frontend;
   localparam int CORE_W     = 32;
   localparam int DIGEST_W   = 512;
   localparam int FIFO_DEPTH = 2;

   logic                clk = 1'b0;
   logic                rst;
   logic [1:0]          cmd_in;
   logic [15:0]         data;
   logic                data_size;
   logic [15:0]         hash;
   logic                busy, ready_for_data, overflow;
   logic [CORE_W-1:0]   core_data;
   logic [2:0]          core_bytes;
   logic                core_last, core_valid, core_ready, core_busy;
   logic [DIGEST_W-1:0] core_digest;
   logic                core_digest_valid;

   always #5 clk = ~clk;

   omsp_hash_frontend #(.CORE_W(CORE_W), .DIGEST_W(DIGEST_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk(clk), .rst(rst), .cmd_in(cmd_in), .data(data), .data_size(data_size),
      .hash(hash), .busy(busy), .ready_for_data(ready_for_data), .overflow(overflow),
      .core_data(core_data), .core_bytes(core_bytes), .core_last(core_last),
      .core_valid(core_valid), .core_ready(core_ready), .core_busy(core_busy),
      .core_digest(core_digest), .core_digest_valid(core_digest_valid)
   );

   typedef struct packed {
      logic [31:0] d;
      logic [2:0]  b;
      logic        l;
   } beat_t;

   typedef struct packed {
      logic [3:0]       n_ops;
      logic [3:0][15:0] d;
      logic [3:0]       sz;
      logic [1:0]       n_beats;
      beat_t [1:0]      exp;
   } vec_t;

   beat_t       sb[$];
   beat_t       e;
   int          n_tests = 0;
   int          n_fail  = 0;
   logic        prev_stall = 1'b0;
   logic [35:0] prev_beat  = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Scoreboard consumer: every accepted beat must match the oldest expected one.
   always @(negedge clk) begin
      if (rst) begin
         prev_stall <= 1'b0;
      end else begin
         if (prev_stall)
            check("head_stable", 64'({core_data, core_bytes, core_last}), 64'(prev_beat));
         if (core_valid && core_ready) begin
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_beat: got %h, expected no beat", core_data);
            end else begin
               e = sb.pop_front();
               check("beat_data", 64'(core_data), 64'(e.d));
               check("beat_bytes", 64'(core_bytes), 64'(e.b));
               check("beat_last", 64'(core_last), 64'(e.l));
            end
         end
         prev_stall <= core_valid && !core_ready;
         prev_beat  <= {core_data, core_bytes, core_last};
      end
   end

   task automatic cyc(input logic [1:0] c, input logic [15:0] d, input logic sz);
      @(posedge clk);
      #1;
      cmd_in    = c;
      data      = d;
      data_size = sz;
   endtask

   task automatic wr(input logic [15:0] d, input logic sz);
      cyc(2'b10, d, sz);
   endtask

   task automatic idle();
      cyc(2'b00, 16'h0000, 1'b0);
   endtask

   task automatic drain_and_digest(input logic [DIGEST_W-1:0] dg);
      int k;
      k = 0;
      while ((sb.size() != 0 || core_valid) && k < 200) begin
         idle();
         k++;
      end
      check("drain_in_time", 64'(k < 200), 64'd1);
      check("busy_wait_digest", 64'(busy), 64'd1);
      check("rdy_wait_digest", 64'(ready_for_data), 64'd0);
      @(posedge clk);
      #1;
      core_digest       = dg;
      core_digest_valid = 1'b1;
      @(posedge clk);
      #1;
      core_digest_valid = 1'b0;
   endtask

   function automatic vec_t mk(input int n, input logic [63:0] d, input logic [3:0] sz,
                               input int nb, input logic [35:0] b0, input logic [35:0] b1);
      vec_t v;
      v.n_ops   = 4'(n);
      v.d       = d;
      v.sz      = sz;
      v.n_beats = 2'(nb);
      v.exp[0]  = b0;
      v.exp[1]  = b1;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      vec_t                vecs[6];
      logic [DIGEST_W-1:0] pat;

      vecs[0] = mk(2, 64'h0000_0000_6364_6162, 4'b0011, 2, {32'h61626364, 3'd4, 1'b0}, {32'h00000000, 3'd0, 1'b1});
      vecs[1] = mk(4, 64'h6667_6465_6263_0061, 4'b1110, 2, {32'h61626364, 3'd4, 1'b0}, {32'h65666700, 3'd3, 1'b1});
      vecs[2] = mk(1, 64'h0000_0000_0000_00AA, 4'b0000, 1, {32'hAA000000, 3'd1, 1'b1}, 36'h0);
      vecs[3] = mk(4, 64'h4455_0033_0022_0011, 4'b1000, 2, {32'h11223344, 3'd4, 1'b0}, {32'h55000000, 3'd1, 1'b1});
      vecs[4] = mk(3, 64'h0000_0004_0003_0102, 4'b0001, 2, {32'h01020304, 3'd4, 1'b0}, {32'h00000000, 3'd0, 1'b1});
      vecs[5] = mk(4, 64'h00A7_A5A6_A3A4_A1A2, 4'b0111, 2, {32'hA1A2A3A4, 3'd4, 1'b0}, {32'hA5A6A700, 3'd3, 1'b1});

      rst = 1'b1; cmd_in = 2'b00; data = '0; data_size = 1'b0;
      core_ready = 1'b1; core_busy = 1'b0; core_digest = '0; core_digest_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_hash", 64'(hash), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_ready", 64'(ready_for_data), 64'd1);
      check("rst_overflow", 64'(overflow), 64'd0);
      check("rst_valid", 64'(core_valid), 64'd0);
      check("rst_last", 64'(core_last), 64'd0);
      check("rst_bytes", 64'(core_bytes), 64'd0);
      check("rst_data", 64'(core_data), 64'd0);
      core_busy = 1'b1;
      #1;
      check("busy_core_busy", 64'(busy), 64'd1);
      core_busy = 1'b0;
      cyc(2'b01, 16'h0000, 1'b0);
      cyc(2'b11, 16'h1234, 1'b1);
      idle();
      check("hash_read_idle", 64'(hash), 64'd0);
      check("cmd11_no_write", 64'(busy), 64'd0);

      for (int v = 0; v < 6; v++) begin
         for (int b = 0; b < int'(vecs[v].n_beats); b++) sb.push_back(vecs[v].exp[b]);
         for (int i = 0; i < int'(vecs[v].n_ops); i++) wr(vecs[v].d[i], vecs[v].sz[i]);
         idle();
         drain_and_digest({16{$urandom()}});
         check("busy_after_msg", 64'(busy), 64'd0);
         check("rdy_after_msg", 64'(ready_for_data), 64'd1);
      end

      // Backpressure: two beats fill the FIFO, the fifth word is dropped.
      core_ready = 1'b0;
      sb.push_back({32'h01020304, 3'd4, 1'b0});
      sb.push_back({32'h05060708, 3'd4, 1'b0});
      sb.push_back({32'h00000000, 3'd0, 1'b1});
      wr(16'h0102, 1'b1);
      wr(16'h0304, 1'b1);
      check("valid_before_push", 64'(core_valid), 64'd0);
      wr(16'h0506, 1'b1);
      check("push_latency", 64'(core_valid), 64'd1);
      wr(16'h0708, 1'b1);
      check("rdy_before_fill", 64'(ready_for_data), 64'd1);
      wr(16'h090A, 1'b1);
      check("rdy_after_fill", 64'(ready_for_data), 64'd0);
      check("overflow_not_yet", 64'(overflow), 64'd0);
      idle();
      check("overflow_set", 64'(overflow), 64'd1);
      repeat (3) idle();
      check("busy_flush_stall", 64'(busy), 64'd1);
      check("rdy_flush_stall", 64'(ready_for_data), 64'd0);
      core_ready = 1'b1;
      drain_and_digest({16{$urandom()}});
      check("overflow_sticky", 64'(overflow), 64'd1);

      // Digest readout, including a stray capture pulse that must be ignored.
      for (int i = 0; i < 32; i++) pat[DIGEST_W-1-16*i -: 16] = 16'(i + 1);
      sb.push_back({32'h5A000000, 3'd1, 1'b1});
      wr(16'h005A, 1'b0);
      idle();
      drain_and_digest(pat);
      @(posedge clk);
      #1;
      core_digest       = {DIGEST_W{1'b1}};
      core_digest_valid = 1'b1;
      @(posedge clk);
      #1;
      core_digest_valid = 1'b0;
      for (int i = 0; i < 33; i++) begin
         cyc(2'b01, 16'h0000, 1'b0);
         if (i > 0) check("digest_chunk", 64'(hash), 64'((i - 1) % 32 + 1));
      end
      idle();
      check("digest_wrap", 64'(hash), 64'd1);
      idle();
      check("hash_hold", 64'(hash), 64'd1);

      // Reset in the middle of a stalled message.
      core_ready = 1'b0;
      wr(16'h1111, 1'b1);
      wr(16'h2222, 1'b1);
      wr(16'h3333, 1'b1);
      @(posedge clk);
      #1;
      cmd_in = 2'b00;
      rst    = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("mid_rst_valid", 64'(core_valid), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_overflow", 64'(overflow), 64'd0);
      check("mid_rst_hash", 64'(hash), 64'd0);
      check("mid_rst_ready", 64'(ready_for_data), 64'd1);
      core_ready = 1'b1;
      sb.push_back({32'hAA000000, 3'd1, 1'b1});
      wr(16'h00AA, 1'b0);
      idle();
      drain_and_digest('0);
      check("sb_empty_end", 64'(sb.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
